// File: rtl/pad_bus_responder.sv
// pad_bus_responder: serial pad-bus slave that receives write/read command frames
// and answers reads by driving the shared line after a fixed turnaround.
module pad_bus_responder #(
  parameter int BIT_CYCLES  = 8,
  parameter int TURN_CYCLES = 16
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       pad_c,
  output logic       pad_i,
  output logic       pad_oen,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [6:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_err
);
  localparam int CMAX = BIT_CYCLES > TURN_CYCLES ? BIT_CYCLES : TURN_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES - 2);
  typedef enum logic [2:0] {IDLE, RX_CMD, RX_DATA, TURN, TX} state_t;
  state_t state_q, state_d;
  logic s1_q, sc_q, sp_q, fall;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic act_q, act_d;
  logic [7:0] sh_q, sh_d;
  logic [6:0] cmd_q, cmd_d;
  logic wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, frame_err_q, frame_err_d;
  logic [6:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  assign fall = sp_q & ~sc_q;
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      s1_q <= 1'b1;
      sc_q <= 1'b1;
      sp_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      act_q <= 1'b0;
      sh_q <= '0;
      cmd_q <= '0;
      wr_valid_q <= 1'b0;
      rd_req_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      s1_q <= pad_c;
      sc_q <= s1_q;
      sp_q <= sc_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      act_q <= act_d;
      sh_q <= sh_d;
      cmd_q <= cmd_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q <= rd_req_d;
      frame_err_q <= frame_err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    act_d = act_q;
    sh_d = sh_q;
    cmd_d = cmd_q;
    wr_valid_d = 1'b0;
    rd_req_d = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: if (fall) begin
        state_d = RX_CMD;
        act_d = 1'b1;
        cnt_d = HALF;
        bit_d = '0;
      end
      RX_CMD, RX_DATA:
        // act_q low means still waiting for a start edge (data frame only)
        if (!act_q) begin
          if (fall) begin
            act_d = 1'b1;
            cnt_d = HALF;
            bit_d = '0;
          end
        end else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (bit_q == 4'd0) begin
          if (sc_q) begin
            act_d = 1'b0;
            state_d = state_q == RX_CMD ? IDLE : RX_DATA;
          end else begin
            cnt_d = FULL;
            bit_d = 4'd1;
          end
        end else if (bit_q != 4'd9) begin
          sh_d = {sh_q[6:0], sc_q};
          cnt_d = FULL;
          bit_d = bit_q + 4'd1;
        end else begin
          act_d = 1'b0;
          bit_d = '0;
          if (!sc_q) begin
            frame_err_d = 1'b1;
            state_d = IDLE;
          end else if (state_q == RX_DATA) begin
            wr_valid_d = 1'b1;
            wr_addr_d = cmd_q;
            wr_data_d = sh_q;
            state_d = IDLE;
          end else if (sh_q[7]) begin
            rd_req_d = 1'b1;
            rd_addr_d = sh_q[6:0];
            cnt_d = TURN_LD;
            state_d = TURN;
          end else begin
            cmd_d = sh_q[6:0];
            state_d = RX_DATA;
          end
        end
      TURN: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else begin
        sh_d = rd_data;
        cnt_d = FULL;
        bit_d = '0;
        state_d = TX;
      end
      TX: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else if (bit_q == 4'd9) begin
        bit_d = '0;
        state_d = IDLE;
      end else begin
        if (bit_q != 4'd0) sh_d = {sh_q[6:0], 1'b0};
        bit_d = bit_q + 4'd1;
        cnt_d = FULL;
      end
      default: state_d = IDLE;
    endcase
  end
  // line drive is decoded straight from state so reset releases it asynchronously
  always_comb begin
    pad_oen = state_q != TX;
    pad_i = state_q != TX ? 1'b1 : bit_q == 4'd0 ? 1'b0 : bit_q == 4'd9 ? 1'b1 : sh_q[7];
    busy = state_q != IDLE;
  end
  assign wr_valid = wr_valid_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_req = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_pad_bus_responder.sv
// tb_pad_bus_responder: directed frames with a queue-based scoreboard; a negedge
// monitor checks every pulse and every driven reply against queued expectations.
module tb_pad_bus_responder;
  localparam int B = 8;
  localparam int EV_WR = 1, EV_RD = 2, EV_FE = 4, EV_TX = 8;
  typedef struct {
    int         kind;
    logic [6:0] addr;
    logic [9:0] data;
    logic       abort;
  } ev_t;
  logic CK = 1'b0, RN = 1'b0, pad_c = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic pad_i, pad_oen, wr_valid, rd_req, busy, frame_err;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  ev_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, rd_cyc = 0;
  pad_bus_responder #(.BIT_CYCLES(B), .TURN_CYCLES(16)) dut (
    .CK(CK), .RN(RN), .pad_c(pad_c), .pad_i(pad_i), .pad_oen(pad_oen),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_err(frame_err)
  );
  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    pad_c = 1'b0;
    tick(B);
    for (int i = 7; i >= 0; i--) begin
      pad_c = b[i];
      tick(B);
    end
    pad_c = stop;
    tick(B);
    pad_c = 1'b1;
    tick(2 * B);
  endtask
  task automatic push(input int kind, input logic [6:0] addr, input logic [9:0] data, input logic abort);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.abort = abort;
    q.push_back(e);
  endtask
  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) tick(1);
    chk("idle_timeout", busy, 0);
  endtask
  // monitor
  logic in_tx = 1'b0, tx_abort = 1'b0;
  logic [9:0] fr = '0, fr_exp = '0;
  int k = 0;
  always @(negedge CK) begin
    int front;
    if (wr_valid | rd_req | frame_err) begin
      front = q.size() != 0 ? q[0].kind : 0;
      chk("pulse_kind", {29'd0, frame_err, rd_req, wr_valid}, front);
      if (q.size() != 0) begin
        if (front == EV_WR) begin
          chk("wr_addr", wr_addr, q[0].addr);
          chk("wr_data", wr_data, q[0].data);
        end else if (front == EV_RD) begin
          chk("rd_addr", rd_addr, q[0].addr);
          rd_cyc = cyc;
        end
        void'(q.pop_front());
      end
    end
    if (!in_tx && !pad_oen) begin
      front = q.size() != 0 ? q[0].kind : 0;
      chk("tx_kind", front, EV_TX);
      chk("turn_delay", cyc - rd_cyc, 15);
      if (q.size() != 0) begin
        fr_exp = q[0].data;
        tx_abort = q[0].abort;
        void'(q.pop_front());
      end
      in_tx = 1'b1;
      k = 0;
      fr = '0;
    end
    if (in_tx) begin
      if (pad_oen) begin
        if (tx_abort) chk("tx_abort_by_reset", RN, 0);
        else begin
          chk("tx_len", k, 10 * B);
          chk("tx_bits", fr, fr_exp);
        end
        in_tx = 1'b0;
      end else begin
        if (k % B == B / 2) fr = {fr[8:0], pad_i};
        k++;
      end
    end
  end
  initial begin
    tick(3);
    chk("rst_pad_oen", pad_oen, 1);
    chk("rst_pad_i", pad_i, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {wr_valid, rd_req, frame_err}, 0);
    chk("rst_regs", {wr_addr, wr_data, rd_addr}, 0);
    RN = 1'b1;
    tick(4);
    // write 0x5A to 0x12
    push(EV_WR, 7'h12, 10'h05A, 1'b0);
    send_byte(8'h12, 1'b1);
    chk("mid_write_busy", busy, 1);
    send_byte(8'h5A, 1'b1);
    wait_idle(50);
    chk("write_drained", q.size(), 0);
    // read 0x33 returning 0xC3
    rd_data = 8'hC3;
    push(EV_RD, 7'h33, 10'h0, 1'b0);
    push(EV_TX, 7'h0, 10'b0110000111, 1'b0);
    send_byte(8'hB3, 1'b1);
    wait_idle(200);
    chk("read_drained", q.size(), 0);
    chk("idle_pad_i", pad_i, 1);
    // framing error on command
    push(EV_FE, 7'h0, 10'h0, 1'b0);
    send_byte(8'h12, 1'b0);
    wait_idle(50);
    chk("fe_drained", q.size(), 0);
    // 2-cycle glitch while idle
    pad_c = 1'b0;
    tick(2);
    pad_c = 1'b1;
    tick(4);
    chk("glitch_busy_rise", busy, 1);
    tick(10);
    chk("glitch_busy", busy, 0);
    // second read with different data
    rd_data = 8'h81;
    push(EV_RD, 7'h7F, 10'h0, 1'b0);
    push(EV_TX, 7'h0, 10'b0100000011, 1'b0);
    send_byte(8'hFF, 1'b1);
    wait_idle(200);
    // read aborted by reset 20 cycles into TX
    rd_data = 8'hA5;
    push(EV_RD, 7'h05, 10'h0, 1'b0);
    push(EV_TX, 7'h0, 10'h0, 1'b1);
    send_byte(8'h85, 1'b1);
    for (int i = 0; i < 100 && pad_oen; i++) tick(1);
    chk("tx_started", pad_oen, 0);
    tick(20);
    RN = 1'b0;
    #1;
    chk("abort_pad_oen", pad_oen, 1);
    chk("abort_pad_i", pad_i, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rd_addr", rd_addr, 0);
    tick(3);
    RN = 1'b1;
    tick(4);
    // write 0xFF to 0x00 after reset
    push(EV_WR, 7'h00, 10'h0FF, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_idle(50);
    tick(4);
    chk("final_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
